// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer controller.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_counter_en.sv
// Up-counter datapath with synchronous clear (wins over enable).
module counter_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset)   q_q <= '0;
    else if (clr) q_q <= '0;
    else if (en)  q_q <= q_q + 1'b1;
  end

  assign q = q_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: sequences counter_en with a prescaler,
// start/stop/pause control and one-shot or auto-reload terminal handling.
module interval_timer_ctrl
  import interval_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] period_s_q, period_s_d;
  logic [DIV_W-1:0] div_s_q, div_s_d;
  logic             mode_s_q, mode_s_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en;
  logic             step, terminal;

  counter_en #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .q    (q)
  );

  assign step     = (presc_q == div_s_q);
  assign terminal = (q == period_s_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      period_s_q <= '0;
      div_s_q    <= '0;
      mode_s_q   <= MODE_ONESHOT;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      period_s_q <= period_s_d;
      div_s_q    <= div_s_d;
      mode_s_q   <= mode_s_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    period_s_d = period_s_q;
    div_s_d    = div_s_q;
    mode_s_d   = mode_s_q;
    tick_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          if (state_q == DONE) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            presc_d = '0;
          end
        end else if (start) begin
          period_s_d = period;
          div_s_d    = div;
          mode_s_d   = mode;
          cnt_clr    = 1'b1;
          presc_d    = '0;
          state_d    = RUN;
        end
      end
      RUN, PAUSED: begin
        if (stop) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          presc_d = '0;
        end else if (pause) begin
          state_d = PAUSED;
        end else begin
          // Counting resumes on the same edge pause drops, so a pause of
          // N cycles delays the schedule by exactly N cycles.
          state_d = RUN;
          if (step) begin
            presc_d = '0;
            if (terminal) begin
              tick_d = 1'b1;
              if (mode_s_q == MODE_RELOAD) cnt_clr = 1'b1;
              else                         state_d = DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == PAUSED);
    done_d = (state_d == DONE);
  end

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed, table-driven bench for interval_timer_ctrl plus a tick-spacing sequence.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, mode;
  logic [7:0] period;
  logic [3:0] div;
  logic [7:0] q;
  logic       tick, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  interval_timer_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .period(period), .div(div),
    .q(q), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, sp, pa, md;
    logic [7:0] p;
    logic [3:0] d;
    logic [7:0] eq;
    logic       et, eb, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, st, sp, pa, md, input logic [7:0] p,
                     input logic [3:0] d, input logic [7:0] eq,
                     input logic et, eb, ed);
    vec_t v;
    v.rst = r; v.st = st; v.sp = sp; v.pa = pa; v.md = md; v.p = p; v.d = d;
    v.eq = eq; v.et = et; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endtask

  // idle inputs, expected outputs only
  task automatic idle(input logic [7:0] eq, input logic et, eb, ed);
    add(0, 0, 0, 0, 0, 8'd0, 4'd0, eq, et, eb, ed);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 0; stop = 0; pause = 0; mode = 0; period = 0; div = 0;

    // A: reset, P=5 D=0 auto-reload, tick spacing 6
    add(1, 0, 0, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 8'd5, 4'd0, 8'd0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) idle(8'(k), 0, 1, 0);
    idle(8'd0, 1, 1, 0);
    for (int k = 1; k <= 5; k++) idle(8'(k), 0, 1, 0);
    idle(8'd0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);   // stop in RUN
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);   // stop in IDLE

    // B: one-shot P=3 D=2; inputs wiggle mid-run with no effect
    add(0, 1, 0, 0, 0, 8'd3, 4'd2, 8'd0, 0, 1, 0);
    for (int i = 1; i <= 11; i++) add(0, 0, 0, 0, 1, 8'd7, 4'd0, 8'(i / 3), 0, 1, 0);
    idle(8'd3, 1, 0, 1);
    for (int i = 0; i < 4; i++) idle(8'd3, 0, 0, 1);
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);   // stop from DONE

    // C: P=10 D=0 reload, pause 4 cycles at q=4, start ignored while running
    add(0, 1, 0, 0, 1, 8'd10, 4'd0, 8'd0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) idle(8'(k), 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 8'd0, 4'd0, 8'd4, 0, 1, 0);
    idle(8'd5, 0, 1, 0);
    add(0, 1, 0, 0, 0, 8'd2, 4'd3, 8'd6, 0, 1, 0);  // ignored start
    for (int k = 7; k <= 10; k++) idle(8'(k), 0, 1, 0);
    idle(8'd0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);

    // D: start+stop together from IDLE, then stop at q=7
    add(0, 1, 1, 0, 1, 8'd9, 4'd0, 8'd0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'd20, 4'd0, 8'd0, 0, 1, 0);
    for (int k = 1; k <= 7; k++) idle(8'(k), 0, 1, 0);
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);

    // E: P=0 D=1 reload, period changed mid-run, then restart with P=9
    add(0, 1, 0, 0, 1, 8'd0, 4'd1, 8'd0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) add(0, 0, 0, 0, 1, 8'd9, 4'd1, 8'd0, logic'(i % 2 == 0), 1, 0);
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 8'd9, 4'd1, 8'd0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) idle(8'(i / 2), 0, 1, 0);
    add(0, 0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);

    // F: P=255 one-shot, then restart from DONE and reset mid-run
    add(0, 1, 0, 0, 0, 8'd255, 4'd0, 8'd0, 0, 1, 0);
    for (int k = 1; k <= 255; k++) idle(8'(k), 0, 1, 0);
    idle(8'd255, 1, 0, 1);
    idle(8'd255, 0, 0, 1);
    add(0, 1, 0, 0, 0, 8'd255, 4'd0, 8'd0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) idle(8'(k), 0, 1, 0);
    add(1, 0, 0, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    idle(8'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; start = vecs[i].st; stop = vecs[i].sp;
      pause = vecs[i].pa;  mode = vecs[i].md;  period = vecs[i].p; div = vecs[i].d;
      @(posedge clk); #1;
      chk("q",    i, int'(q),    int'(vecs[i].eq));
      chk("tick", i, int'(tick), int'(vecs[i].et));
      chk("busy", i, int'(busy), int'(vecs[i].eb));
      chk("done", i, int'(done), int'(vecs[i].ed));
    end

    // Tick latency and spacing for P=2 D=3 reload: (P+1)*(D+1) = 12
    @(negedge clk);
    reset = 0; start = 1; stop = 0; pause = 0; mode = 1; period = 8'd2; div = 4'd3;
    @(posedge clk); #1;
    start = 0;
    cnt = 1;
    while (!tick && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("first_tick_latency", 0, cnt, 13);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!tick && cnt < 100);
    chk("tick_spacing", 0, cnt, 12);
    chk("reload_q", 0, int'(q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
